// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a registered carry,
// one bit per clock LSB-first, with sum/cout/ovf published on completion.

module serial_adder_fa (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);
   assign s_o = a_i ^ b_i ^ c_i;
   assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
   logic [WIDTH-1:0] res_q, res_d, sum_q, sum_d;
   logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             fa_s, fa_co;
   logic [WIDTH:0]   res_ext;

   serial_adder_fa u_fa (
      .a_i (opa_q[0]),
      .b_i (opb_q[0]),
      .c_i (carry_q),
      .s_o (fa_s),
      .c_o (fa_co)
   );

   // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
   assign res_ext = {fa_s, res_q};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         opa_q   <= '0;
         opb_q   <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      res_d   = res_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               opa_d   = a;
               opb_d   = b;
               carry_d = cin;
               res_d   = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            opa_d   = opa_q >> 1;
            opb_d   = opb_q >> 1;
            carry_d = fa_co;
            res_d   = res_ext[WIDTH:1];
            cnt_d   = cnt_q + CW'(1);
            // On the MSB step carry_q is the carry into the MSB.
            if (cnt_q == CW'(WIDTH - 1)) begin
               sum_d   = res_ext[WIDTH:1];
               cout_d  = fa_co;
               ovf_d   = carry_q ^ fa_co;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign ready = (state_q == IDLE);
   assign done  = (state_q == DONE);
   assign sum   = sum_q;
   assign cout  = cout_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 directed/random scenarios
// and an exhaustive WIDTH=3 back-to-back sweep against an arithmetic model.
`timescale 1ns/1ps

module tb_serial_adder;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       s8 = 1'b0, c8 = 1'b0, s3 = 1'b0, c3 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic [2:0] a3 = '0, b3 = '0;
   logic       rdy8, dn8, co8, ov8, rdy3, dn3, co3, ov3;
   logic [7:0] sum8;
   logic [2:0] sum3;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8), .cin(c8),
      .ready(rdy8), .done(dn8), .sum(sum8), .cout(co8), .ovf(ov8));

   serial_adder #(.WIDTH(3)) dut3 (
      .clk(clk), .rst(rst), .start(s3), .a(a3), .b(b3), .cin(c3),
      .ready(rdy3), .done(dn3), .sum(sum3), .cout(co3), .ovf(ov3));

   function automatic bit rdy_of(int w);  return (w == 8) ? rdy8 : rdy3; endfunction
   function automatic bit dn_of(int w);   return (w == 8) ? dn8  : dn3;  endfunction
   function automatic logic [7:0] sum_of(int w); return (w == 8) ? sum8 : {5'b0, sum3}; endfunction
   function automatic bit co_of(int w);   return (w == 8) ? co8  : co3;  endfunction
   function automatic bit ov_of(int w);   return (w == 8) ? ov8  : ov3;  endfunction

   // Reference: plain integer arithmetic, signed range test for overflow.
   function automatic void model(input int w, input int a, input int b, input int ci,
                                 output logic [7:0] s, output bit co, output bit ov);
      int tot, sa, sb, st;
      tot = a + b + ci;
      s   = 8'(tot % (1 << w));
      co  = (tot >> w) != 0;
      sa  = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
      sb  = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
      st  = sa + sb + ci;
      ov  = (st > (1 << (w - 1)) - 1) || (st < -(1 << (w - 1)));
   endfunction

   // Waits for ready, issues one addition, returns at the negedge where done=1.
   // held: sum/cout/ovf kept their prior values every cycle before done.
   task automatic do_op(input int w, input logic [7:0] a, input logic [7:0] b,
                        input bit ci, input bit disturb,
                        output logic [7:0] s, output bit co, output bit ov,
                        output int n, output int wc, output bit to, output bit held);
      logic [7:0] ps;
      bit pco, pov;
      s = '0; co = 0; ov = 0; n = 0; wc = 0; to = 0; held = 1;
      @(negedge clk);
      while (!rdy_of(w)) begin
         wc++;
         if (wc > 50) begin to = 1; return; end
         @(negedge clk);
      end
      ps = sum_of(w); pco = co_of(w); pov = ov_of(w);
      if (w == 8) begin a8 = a; b8 = b; c8 = ci; s8 = 1; end
      else        begin a3 = a[2:0]; b3 = b[2:0]; c3 = ci; s3 = 1; end
      @(negedge clk);
      s8 = 0; s3 = 0;
      n = 1;
      while (!dn_of(w)) begin
         if (sum_of(w) !== ps || co_of(w) !== pco || ov_of(w) !== pov) held = 0;
         if (disturb && n == 3) begin s8 = 1; a8 = 8'hAA; b8 = 8'h55; c8 = 1; end
         if (disturb && n == 4) s8 = 0;
         n++;
         if (n > 40) begin to = 1; return; end
         @(negedge clk);
      end
      s = sum_of(w); co = co_of(w); ov = ov_of(w);
   endtask

   task automatic test_reset();
      rst = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 0;
      checks++; if (rdy8 !== 1'b1 || dn8 !== 1'b0) begin errors++;
         $display("FAIL reset_ctl8 ready=%b done=%b expected 1/0", rdy8, dn8); end
      checks++; if (sum8 !== 8'h00 || co8 !== 1'b0 || ov8 !== 1'b0) begin errors++;
         $display("FAIL reset_out8 sum=%h cout=%b ovf=%b expected 00/0/0", sum8, co8, ov8); end
      checks++; if (rdy3 !== 1'b1 || dn3 !== 1'b0 || sum3 !== 3'd0 || co3 !== 1'b0 || ov3 !== 1'b0) begin errors++;
         $display("FAIL reset_w3 ready=%b done=%b sum=%h cout=%b ovf=%b", rdy3, dn3, sum3, co3, ov3); end
   endtask

   task automatic test_latency();
      logic [7:0] s; bit co, ov, to, held; int n, wc;
      do_op(8, 8'h00, 8'h00, 0, 0, s, co, ov, n, wc, to, held);
      checks++; if (to || n !== 9) begin errors++;
         $display("FAIL latency cycles=%0d timeout=%b expected 9", n, to); end
      checks++; if (s !== 8'h00 || co !== 0 || ov !== 0) begin errors++;
         $display("FAIL zero_add sum=%h cout=%b ovf=%b expected 00/0/0", s, co, ov); end
      checks++; if (rdy8 !== 1'b0) begin errors++;
         $display("FAIL ready_in_done ready=%b expected 0", rdy8); end
      @(negedge clk);
      checks++; if (rdy8 !== 1'b1 || dn8 !== 1'b0) begin errors++;
         $display("FAIL ready_return ready=%b done=%b expected 1/0", rdy8, dn8); end
   endtask

   task automatic test_directed();
      logic [7:0] va [4] = '{8'hFF, 8'h80, 8'h7F, 8'h0F};
      logic [7:0] vb [4] = '{8'h01, 8'h80, 8'h01, 8'hF0};
      bit         vc [4] = '{0, 0, 0, 1};
      logic [7:0] s, es; bit co, ov, eco, eov, to, held; int n, wc;
      for (int i = 0; i < 4; i++) begin
         do_op(8, va[i], vb[i], vc[i], 0, s, co, ov, n, wc, to, held);
         model(8, va[i], vb[i], vc[i], es, eco, eov);
         checks++; if (to || s !== es || co !== eco || ov !== eov) begin errors++;
            $display("FAIL directed_%0d sum=%h cout=%b ovf=%b to=%b expected %h/%b/%b",
                     i, s, co, ov, to, es, eco, eov); end
         checks++; if (!held) begin errors++;
            $display("FAIL hold_%0d outputs changed before done, expected held", i); end
      end
   endtask

   task automatic test_ignore_start();
      logic [7:0] s; bit co, ov, to, held; int n, wc, extra;
      do_op(8, 8'h12, 8'h34, 0, 1, s, co, ov, n, wc, to, held);
      checks++; if (to || s !== 8'h46 || co !== 0 || ov !== 0 || n !== 9) begin errors++;
         $display("FAIL ignore_start sum=%h cout=%b ovf=%b n=%0d expected 46/0/0 n=9", s, co, ov, n); end
      extra = 0;
      repeat (12) begin @(negedge clk); if (dn8) extra++; end
      checks++; if (extra !== 0) begin errors++;
         $display("FAIL single_done extra_done=%0d expected 0", extra); end
   endtask

   task automatic test_abort();
      logic [7:0] s; bit co, ov, to, held; int n, wc, seen;
      @(negedge clk);
      a8 = 8'hFF; b8 = 8'hFF; c8 = 1; s8 = 1;
      @(negedge clk); s8 = 0;
      repeat (2) @(negedge clk);
      rst = 1;
      @(negedge clk); rst = 0;
      checks++; if (rdy8 !== 1'b1 || sum8 !== 8'h00 || co8 !== 0 || ov8 !== 0) begin errors++;
         $display("FAIL abort_state ready=%b sum=%h cout=%b ovf=%b expected 1/00/0/0", rdy8, sum8, co8, ov8); end
      seen = 0;
      repeat (12) begin @(negedge clk); if (dn8) seen++; end
      checks++; if (seen !== 0) begin errors++;
         $display("FAIL abort_no_done done_pulses=%0d expected 0", seen); end
      do_op(8, 8'h01, 8'h01, 0, 0, s, co, ov, n, wc, to, held);
      checks++; if (to || s !== 8'h02 || co !== 0 || ov !== 0) begin errors++;
         $display("FAIL after_abort sum=%h cout=%b ovf=%b expected 02/0/0", s, co, ov); end
   endtask

   task automatic test_random();
      logic [7:0] s, es, ra, rb; bit co, ov, eco, eov, to, held, rc; int n, wc;
      for (int i = 0; i < 30; i++) begin
         ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
         do_op(8, ra, rb, rc, 0, s, co, ov, n, wc, to, held);
         model(8, ra, rb, rc, es, eco, eov);
         checks++; if (to || s !== es || co !== eco || ov !== eov || n !== 9) begin errors++;
            $display("FAIL random_%0d %h+%h+%b sum=%h cout=%b ovf=%b n=%0d expected %h/%b/%b",
                     i, ra, rb, rc, s, co, ov, n, es, eco, eov); end
      end
   endtask

   task automatic test_back_to_back_w3();
      logic [7:0] s, es; bit co, ov, eco, eov, to, held; int n, wc;
      for (int i = 0; i < 128; i++) begin
         do_op(3, 8'(i & 7), 8'((i >> 3) & 7), i[6], 0, s, co, ov, n, wc, to, held);
         model(3, i & 7, (i >> 3) & 7, (i >> 6) & 1, es, eco, eov);
         checks++; if (to || s !== es || co !== eco || ov !== eov || n !== 4) begin errors++;
            $display("FAIL w3_%0d sum=%h cout=%b ovf=%b n=%0d expected %h/%b/%b n=4",
                     i, s, co, ov, n, es, eco, eov); end
         if (i > 0) begin
            checks++; if (wc !== 0) begin errors++;
               $display("FAIL w3_spacing_%0d extra_wait=%0d expected 0", i, wc); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_directed();
      test_ignore_start();
      test_abort();
      test_random();
      test_back_to_back_w3();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish, expected completion");
      $fatal(1);
   end
endmodule
